// File: rtl/bm_pkg.sv
// Shared definitions for the block-matching disparity pipeline.
// Holds the SAD intermediate word layout, which the update stage also uses.
package bm_pkg;

    localparam int unsigned SAD_W         = 64;
    localparam int unsigned SAD_DISP1_LSB = 56;
    localparam int unsigned SAD_FRAC_LSB  = 48;
    localparam int unsigned SAD_MIN1_LSB  = 32;
    localparam int unsigned SAD_DISP2_LSB = 24;
    localparam int unsigned SAD_RSVD_LSB  = 16;
    localparam int unsigned SAD_MIN2_LSB  = 0;

    localparam logic [15:0] BM_INVALID_DISP = 16'hFFFF;
    localparam logic [3:0]  BM_LAST_PHASE   = 4'd7;

    function automatic logic [SAD_W-1:0] bm_pack_sad(
        input logic [7:0]  disp1,
        input logic [7:0]  frac,
        input logic [15:0] min1,
        input logic [7:0]  disp2,
        input logic [15:0] min2
    );
        logic [SAD_W-1:0] w;
        w = '0;
        w[SAD_DISP1_LSB +: 8]  = disp1;
        w[SAD_FRAC_LSB  +: 8]  = frac;
        w[SAD_MIN1_LSB  +: 16] = min1;
        w[SAD_DISP2_LSB +: 8]  = disp2;
        w[SAD_RSVD_LSB  +: 8]  = 8'h00;
        w[SAD_MIN2_LSB  +: 16] = min2;
        return w;
    endfunction

endpackage

// File: rtl/bm_wb_fifo.sv
// Small synchronous FIFO for the disparity output stream ({last, data}).
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module bm_wb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/bm_calc_wb.sv
// Write-back and result-emit stage of the block-matching disparity calculator.
// Define BM_WB_UNIQ_EN to enable the uniqueness test on the final phase.
module bm_calc_wb
    import bm_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [3:0]  LAST_PHASE = BM_LAST_PHASE
) (
    input  logic        rst_n,
    input  logic        clk,
    input  logic [3:0]  dphase,
    input  logic [2:0]  uniq_shift,
    input  logic        vin,
    input  logic        upd,
    input  logic [15:0] upd_min1,
    input  logic [15:0] upd_min2,
    input  logic [7:0]  upd_disp1,
    input  logic [7:0]  upd_disp2,
    input  logic [7:0]  upd_frac,
    input  logic [7:0]  new_frac,
    output logic [9:0]  sad_wraddr,
    output logic        sad_wren,
    output logic [63:0] sad_dout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic        ovf,
    input  logic        ovf_clr
);

    logic [7:0]  frac_w;
    logic [63:0] sad_word;
    logic        uniq;
    logic [15:0] emit_data;
    logic        last_rec;
    logic [9:0]  addr_cnt;

    logic        stg_valid;
    logic [15:0] stg_data;
    logic        push_q;
    logic [15:0] push_data;
    logic        push_last;

    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic [16:0] fifo_dout;

    assign frac_w   = upd ? new_frac : upd_frac;
    assign sad_word = bm_pack_sad(upd_disp1, frac_w, upd_min1, upd_disp2, upd_min2);

`ifdef BM_WB_UNIQ_EN
    logic [16:0] sad_gap;
    logic [16:0] sad_margin;

    always_comb begin
        sad_gap    = {1'b0, upd_min2} - {1'b0, upd_min1};
        sad_margin = {1'b0, upd_min1 >> uniq_shift};
        uniq       = (upd_min2 >= upd_min1) && (sad_gap > sad_margin);
    end
`else
    logic unused_uniq_shift;

    assign unused_uniq_shift = ^uniq_shift;
    assign uniq              = 1'b1;
`endif

    assign emit_data = uniq ? {upd_disp1, frac_w} : BM_INVALID_DISP;
    assign last_rec  = vin && (dphase == LAST_PHASE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_cnt   <= '0;
            sad_wraddr <= '0;
            sad_wren   <= 1'b0;
            sad_dout   <= '0;
        end else begin
            sad_wren <= vin;
            if (vin) begin
                sad_wraddr <= addr_cnt;
                addr_cnt   <= addr_cnt + 10'd1;
                sad_dout   <= sad_word;
            end else begin
                sad_wraddr <= '0;
                addr_cnt   <= '0;
            end
        end
    end

    // A held stage entry always leaves the next cycle: either the next record
    // displaces it, or vin dropped and it is the last pixel of the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid <= 1'b0;
            stg_data  <= '0;
            push_q    <= 1'b0;
            push_data <= '0;
            push_last <= 1'b0;
        end else begin
            stg_valid <= last_rec;
            if (last_rec) stg_data <= emit_data;
            push_q <= stg_valid;
            if (stg_valid) begin
                push_data <= stg_data;
                push_last <= !vin;
            end
        end
    end

    assign fifo_pop = out_valid && out_ready;

    bm_wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (17)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_q),
        .din   ({push_last, push_data}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid             = !fifo_empty;
    assign {out_last, out_data}  = out_valid ? fifo_dout : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end else if (push_q && fifo_full && !fifo_pop) begin
            ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bm_calc_wb.sv
// Self-checking bench for bm_calc_wb: vector table, directed corner sequences
// and randomized bursts against a line-level reference model.
module tb_bm_calc_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  dphase;
    logic [2:0]  uniq_shift;
    logic        vin;
    logic        upd;
    logic [15:0] upd_min1;
    logic [15:0] upd_min2;
    logic [7:0]  upd_disp1;
    logic [7:0]  upd_disp2;
    logic [7:0]  upd_frac;
    logic [7:0]  new_frac;
    logic [9:0]  sad_wraddr;
    logic        sad_wren;
    logic [63:0] sad_dout;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        ovf;
    logic        ovf_clr;

    bm_calc_wb #(
        .FIFO_DEPTH (4),
        .LAST_PHASE (4'd7)
    ) dut (
        .rst_n      (rst_n),
        .clk        (clk),
        .dphase     (dphase),
        .uniq_shift (uniq_shift),
        .vin        (vin),
        .upd        (upd),
        .upd_min1   (upd_min1),
        .upd_min2   (upd_min2),
        .upd_disp1  (upd_disp1),
        .upd_disp2  (upd_disp2),
        .upd_frac   (upd_frac),
        .new_frac   (new_frac),
        .sad_wraddr (sad_wraddr),
        .sad_wren   (sad_wren),
        .sad_dout   (sad_dout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .ovf        (ovf),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

`ifdef BM_WB_UNIQ_EN
    localparam bit UNIQ_ON = 1'b1;
`else
    localparam bit UNIQ_ON = 1'b0;
`endif

    typedef struct {
        logic [3:0]  ph;
        logic [2:0]  sh;
        logic        upd;
        logic [15:0] m1;
        logic [15:0] m2;
        logic [7:0]  d1;
        logic [7:0]  d2;
        logic [7:0]  uf;
        logic [7:0]  nf;
        logic [63:0] dout;
        logic [15:0] emit_u;
        logic [15:0] emit_n;
    } vec_t;

    vec_t        tbl [10];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          run_idx;
    bit          have_pend;
    logic [15:0] pend_val;
    logic [16:0] exp_q [$];
    logic [63:0] last_dout;
    bit          mdl_out;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_emit();
        int         m1;
        int         m2;
        logic [7:0] fr;
        m1 = int'(upd_min1);
        m2 = int'(upd_min2);
        fr = upd ? new_frac : upd_frac;
        if (UNIQ_ON && !((m2 >= m1) && ((m2 - m1) > (m1 >> uniq_shift)))) return 16'hFFFF;
        return {upd_disp1, fr};
    endfunction

    function automatic logic [63:0] ref_pack();
        logic [7:0] fr;
        fr = upd ? new_frac : upd_frac;
        return {upd_disp1, fr, upd_min1, upd_disp2, 8'h00, upd_min2};
    endfunction

    task automatic model_clear();
        run_idx   = 0;
        have_pend = 1'b0;
        exp_q.delete();
        last_dout = '0;
    endtask

    // One clock cycle: check any handshake taken at this edge, predict the
    // write-port result, advance the line model, then check after the edge.
    task automatic step();
        logic [16:0] h;
        logic        e_wren;
        logic [9:0]  e_addr;
        if (mdl_out && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL out_unexpected: got %h, expected no output", {out_last, out_data});
            end else begin
                h = exp_q.pop_front();
                chk("out_data", out_data, h[15:0]);
                chk("out_last", out_last, h[16]);
            end
        end
        e_wren = vin;
        if (vin) begin
            e_addr    = 10'(run_idx % 1024);
            last_dout = ref_pack();
            run_idx++;
            if (mdl_out && dphase == 4'd7) begin
                if (have_pend) exp_q.push_back({1'b0, pend_val});
                pend_val  = ref_emit();
                have_pend = 1'b1;
            end
        end else begin
            e_addr  = '0;
            run_idx = 0;
            if (have_pend) exp_q.push_back({1'b1, pend_val});
            have_pend = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("sad_wren", sad_wren, e_wren);
        chk("sad_wraddr", sad_wraddr, e_addr);
        chk("sad_dout", sad_dout, last_dout);
    endtask

    task automatic drain(input int budget, input bit rand_ready);
        int w;
        vin = 1'b0;
        step();
        w = 0;
        while ((exp_q.size() != 0 || have_pend) && w < budget) begin
            out_ready = rand_ready ? 1'($urandom) : 1'b1;
            step();
            w++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic set_rec(input logic u, input logic [15:0] m1, input logic [15:0] m2,
                           input logic [7:0] d1, input logic [7:0] d2,
                           input logic [7:0] uf, input logic [7:0] nf);
        upd = u; upd_min1 = m1; upd_min2 = m2;
        upd_disp1 = d1; upd_disp2 = d2; upd_frac = uf; new_frac = nf;
    endtask

    task automatic rand_rec();
        int t;
        upd_min1   = 16'($urandom);
        upd        = 1'($urandom);
        upd_disp1  = 8'($urandom);
        upd_disp2  = 8'($urandom);
        upd_frac   = 8'($urandom);
        new_frac   = 8'($urandom);
        uniq_shift = 3'($urandom);
        case ($urandom_range(2, 0))
            0: t = int'($urandom_range(65535, 0));
            1: t = int'(upd_min1) + int'($urandom_range(64, 0));
            default: t = int'(upd_min1) - int'($urandom_range(8, 0));
        endcase
        if (t > 65535) t = 65535;
        if (t < 0) t = 0;
        upd_min2 = 16'(t);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wraddr"}, sad_wraddr, 0);
        chk({tag, "_wren"}, sad_wren, 0);
        chk({tag, "_dout"}, sad_dout, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_ovf"}, ovf, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before the end of the test");
        $fatal(1);
    end

    initial begin
        int          w;
        logic [15:0] e;

        tbl[0] = '{4'd7, 3'd2, 1'b1, 16'd100,   16'd120,   8'h45, 8'h12, 8'h11, 8'h80, 64'h4580_0064_1200_0078, 16'hFFFF, 16'h4580};
        tbl[1] = '{4'd7, 3'd2, 1'b1, 16'd100,   16'd130,   8'h45, 8'h12, 8'h11, 8'h80, 64'h4580_0064_1200_0082, 16'h4580, 16'h4580};
        tbl[2] = '{4'd7, 3'd0, 1'b0, 16'h0010,  16'h0100,  8'h21, 8'h22, 8'h33, 8'h99, 64'h2133_0010_2200_0100, 16'h2133, 16'h2133};
        tbl[3] = '{4'd7, 3'd7, 1'b1, 16'h0200,  16'h0100,  8'h7F, 8'h01, 8'h00, 8'h5A, 64'h7F5A_0200_0100_0100, 16'hFFFF, 16'h7F5A};
        tbl[4] = '{4'd7, 3'd3, 1'b1, 16'h0040,  16'h0048,  8'h03, 8'h04, 8'h00, 8'h01, 64'h0301_0040_0400_0048, 16'hFFFF, 16'h0301};
        tbl[5] = '{4'd7, 3'd3, 1'b1, 16'h0040,  16'h0049,  8'h03, 8'h04, 8'h00, 8'h01, 64'h0301_0040_0400_0049, 16'h0301, 16'h0301};
        tbl[6] = '{4'd7, 3'd0, 1'b0, 16'hFFFF,  16'hFFFF,  8'hFF, 8'hEE, 8'hAB, 8'h00, 64'hFFAB_FFFF_EE00_FFFF, 16'hFFFF, 16'hFFAB};
        tbl[7] = '{4'd3, 3'd0, 1'b1, 16'h0000,  16'hFFFF,  8'h01, 8'h02, 8'h00, 8'h10, 64'h0110_0000_0200_FFFF, 16'h0000, 16'h0000};
        tbl[8] = '{4'd7, 3'd0, 1'b1, 16'h0000,  16'hFFFF,  8'h0A, 8'h0B, 8'h00, 8'h0C, 64'h0A0C_0000_0B00_FFFF, 16'h0A0C, 16'h0A0C};
        tbl[9] = '{4'd7, 3'd5, 1'b1, 16'h0000,  16'h0000,  8'h01, 8'h02, 8'h00, 8'h10, 64'h0110_0000_0200_0000, 16'hFFFF, 16'h0110};

        rst_n = 1'b0; vin = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
        dphase = '0; uniq_shift = '0;
        set_rec(1'b0, '0, '0, '0, '0, '0, '0);
        mdl_out = 1'b1;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-record lines from the vector table.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            dphase = tbl[i].ph;
            uniq_shift = tbl[i].sh;
            set_rec(tbl[i].upd, tbl[i].m1, tbl[i].m2, tbl[i].d1, tbl[i].d2, tbl[i].uf, tbl[i].nf);
            vin = 1'b1;
            step();
            chk("tbl_dout", sad_dout, tbl[i].dout);
            chk("tbl_addr", sad_wraddr, 0);
            vin = 1'b0;
            if (tbl[i].ph == 4'd7) begin
                w = 0;
                while (!out_valid && w < 8) begin
                    step();
                    w++;
                end
                chk("tbl_latency", w, 2);
                chk("tbl_out", out_data, UNIQ_ON ? tbl[i].emit_u : tbl[i].emit_n);
                chk("tbl_last", out_last, 1);
            end else begin
                repeat (4) step();
                chk("tbl_noemit", out_valid, 0);
            end
            drain(20, 1'b0);
        end

        // Five-record line on a non-final phase: writes only.
        dphase = 4'd2;
        uniq_shift = 3'd0;
        set_rec(1'b1, 16'h0010, 16'h0100, 8'h45, 8'h01, 8'h00, 8'h80);
        for (int k = 0; k < 5; k++) begin
            vin = 1'b1;
            step();
            chk("b5_addr", sad_wraddr, k);
            chk("b5_hi", sad_dout[63:48], 16'h4580);
            chk("b5_nopush", out_valid, 0);
        end
        vin = 1'b0;
        repeat (4) begin
            step();
            chk("b5_nopush", out_valid, 0);
        end

        // Full FIFO accepting pushes that coincide with pops.
        dphase = 4'd7;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rand_rec();
            vin = 1'b1;
            step();
        end
        vin = 1'b0;
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            rand_rec();
            if (k == 2) out_ready = 1'b1;
            vin = 1'b1;
            step();
        end
        drain(40, 1'b0);
        chk("full_pushpop_ovf", ovf, 0);

        // Eight-record line into a stalled FIFO: overflow, hold, clear priority.
        mdl_out = 1'b0;
        out_ready = 1'b0;
        uniq_shift = 3'd0;
        for (int k = 0; k < 8; k++) begin
            set_rec(1'b1, 16'd10, 16'd1000, 8'(8'h10 + k), 8'h00, 8'h00, 8'(k));
            vin = 1'b1;
            step();
            chk("ovf_timing", ovf, (k >= 6) ? 1 : 0);
            if (k >= 5) chk("hold_data", out_data, 16'h1000);
        end
        vin = 1'b0;
        step();
        chk("ovf_sticky", ovf, 1);
        chk("hold_data", out_data, 16'h1000);
        ovf_clr = 1'b1;
        step();
        chk("ovf_clr_prio", ovf, 0);
        ovf_clr = 1'b0;
        step();
        chk("ovf_after_clr", ovf, 0);
        chk("hold_last", out_last, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e = {8'(8'h10 + i), 8'(i)};
            chk("ovf_valid", out_valid, 1);
            chk("ovf_data", out_data, e);
            chk("ovf_last", out_last, 0);
            step();
        end
        chk("ovf_empty", out_valid, 0);
        mdl_out = 1'b1;
        model_clear();

        // Address wrap over a 1030-record line.
        dphase = 4'd2;
        for (int k = 0; k < 1030; k++) begin
            rand_rec();
            vin = 1'b1;
            step();
            if (k == 1023) chk("wrap_hi", sad_wraddr, 1023);
            if (k == 1024) chk("wrap_lo", sad_wraddr, 0);
        end
        vin = 1'b0;
        step();

        // Reset in the middle of a final-phase line with entries in flight.
        dphase = 4'd7;
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            rand_rec();
            vin = 1'b1;
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        vin = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_reset_outputs("inrst");
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rand_rec();
            vin = 1'b1;
            step();
            if (k == 0) chk("rst_addr0", sad_wraddr, 0);
        end
        drain(40, 1'b0);

        // Randomized lines with a random downstream stall pattern.
        for (int b = 0; b < 40; b++) begin
            dphase = ($urandom_range(1, 0) == 1) ? 4'd7 : 4'($urandom_range(6, 0));
            w = int'($urandom_range(4, 1));
            for (int k = 0; k < w; k++) begin
                rand_rec();
                out_ready = 1'($urandom);
                vin = 1'b1;
                step();
            end
            drain(60, 1'b1);
        end

        out_ready = 1'b1;
        repeat (6) step();
        chk("final_empty", out_valid, 0);
        chk("final_ovf", ovf, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
